// File: rtl/moore_seq_detector_p_pkg.sv
// moore_seq_pkg: shared constants and helpers for the parametrised Moore
// sequence detector.
//   clog2      - ceiling log2 for constant sizing
//   state_w    - state register width for a PAT_W-bit pattern (0..PAT_W)
//   idle_st    - S0, nothing matched
//   det_st     - S_PAT_W, full pattern matched
//   DEFAULT_PAT - pattern in force after reset for the 4-bit build
package moore_seq_pkg;

  localparam logic [3:0] DEFAULT_PAT = 4'b1011;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int state_w(input int pat_w);
    return clog2(pat_w + 1);
  endfunction

  function automatic int idle_st(input int pat_w);
    return 0 * pat_w;
  endfunction

  function automatic int det_st(input int pat_w);
    return pat_w;
  endfunction

endpackage

// File: rtl/moore_seq_detector_p_if.sv
// moore_seq_detector_p_if: serial data / control / status bundle.
//   master - drives in, in_valid, pat_load, pat_in, overlap_en, count_clr
//   slave  - the detector; drives out, match_count, count_sat
interface moore_seq_detector_p_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             in;
  logic             in_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap_en;
  logic             count_clr;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output in, in_valid, pat_load, pat_in, overlap_en, count_clr,
    input  out, match_count, count_sat
  );

  modport slave (
    input  in, in_valid, pat_load, pat_in, overlap_en, count_clr,
    output out, match_count, count_sat
  );
endinterface

// File: rtl/moore_seq_detector_p_fallback.sv
// seq_fallback: combinational next-state for the runtime KMP-style matcher.
//   k          - current matched length (0..PAT_W)
//   hist       - last PAT_W-1 accepted bits, newest in bit 0
//   b          - incoming valid bit
//   pat        - active pattern, MSB is the first bit of the sequence
//   overlap_en - 0 makes DETECT behave like S0 for this bit
//   nxt        - longest j <= min(k+1, PAT_W) whose last j window bits
//                equal the top j pattern bits, else 0
module seq_fallback import moore_seq_pkg::*; #(
  parameter int PAT_W = 4,
  parameter int SW    = state_w(PAT_W)
)(
  input  logic [SW-1:0]    k,
  input  logic [PAT_W-2:0] hist,
  input  logic             b,
  input  logic [PAT_W-1:0] pat,
  input  logic             overlap_en,
  output logic [SW-1:0]    nxt
);

  logic [PAT_W-1:0] win, top, msk;
  int               k_eff, lim;

  always_comb begin
    win   = {hist, b};
    k_eff = (k == SW'(PAT_W) && !overlap_en) ? 0 : int'(k);
    lim   = (k_eff + 1 > PAT_W) ? PAT_W : k_eff + 1;
    nxt   = '0;
    top   = '0;
    msk   = '0;
    // Ascending scan: the last passing j is the longest valid prefix, so a
    // mismatch can never skip a shorter one. History bits beyond k are
    // excluded by the lim bound, not by masking the window.
    for (int j = 1; j <= PAT_W; j++) begin
      top = pat >> (PAT_W - j);
      msk = {PAT_W{1'b1}} >> (PAT_W - j);
      if (j <= lim && ((win ^ top) & msk) == '0) nxt = j[SW-1:0];
    end
  end

endmodule

// File: rtl/moore_seq_detector_p.sv
// moore_seq_detector_p: Moore detector for a runtime-loadable PAT_W-bit
// serial pattern with optional overlap and a saturating match counter.
//   clk, rst_n - clock, async active-low reset
//   bus.slave  - in/in_valid stream, pat_load/pat_in, overlap_en,
//                count_clr; out (registered DETECT flag), match_count,
//                count_sat
module moore_seq_detector_p import moore_seq_pkg::*; #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_PAT)
)(
  input logic                  clk,
  input logic                  rst_n,
  moore_seq_detector_p_if.slave bus
);

  localparam int            SW     = state_w(PAT_W);
  localparam logic [SW-1:0] S_IDLE = SW'(idle_st(PAT_W));
  localparam logic [SW-1:0] S_DET  = SW'(det_st(PAT_W));

  logic [SW-1:0]    state, state_nxt, fb_nxt;
  logic [PAT_W-2:0] hist, hist_nxt;
  logic [PAT_W-1:0] pat, pat_nxt, win;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_q, out_nxt, sat_q, hit;

  seq_fallback #(.PAT_W(PAT_W), .SW(SW)) u_fb (
    .k          (state),
    .hist       (hist),
    .b          (bus.in),
    .pat        (pat),
    .overlap_en (bus.overlap_en),
    .nxt        (fb_nxt)
  );

  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    pat_nxt   = pat;
    out_nxt   = out_q;
    hit       = 1'b0;
    win       = {hist, bus.in};
    // A load discards any bit presented in the same cycle.
    if (bus.pat_load) begin
      pat_nxt   = bus.pat_in;
      state_nxt = S_IDLE;
      hist_nxt  = '0;
      out_nxt   = 1'b0;
    end else if (bus.in_valid) begin
      state_nxt = fb_nxt;
      hist_nxt  = win[PAT_W-2:0];
      out_nxt   = (fb_nxt == S_DET);
      hit       = out_nxt;
    end
    if (bus.count_clr)          cnt_nxt = '0;
    else if (hit && cnt != '1)  cnt_nxt = cnt + CNT_W'(1);
    else                        cnt_nxt = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      hist  <= '0;
      pat   <= RST_PAT;
      out_q <= 1'b0;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_nxt;
      hist  <= hist_nxt;
      pat   <= pat_nxt;
      out_q <= out_nxt;
      cnt   <= cnt_nxt;
      sat_q <= &cnt_nxt;
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = cnt;
  assign bus.count_sat   = sat_q;

endmodule

// File: tb/tb_moore_seq_detector_p.sv
// Bench for moore_seq_detector_p: two instances (8-bit and 2-bit counters)
// share one stimulus stream; a suffix/prefix queue model scores every cycle,
// a vector table and hand sequences pin the documented scenarios.
module tb_moore_seq_detector_p;
  localparam int PAT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  moore_seq_detector_p_if #(.PAT_W(PAT_W), .CNT_W(8)) if_a ();
  moore_seq_detector_p_if #(.PAT_W(PAT_W), .CNT_W(2)) if_b ();

  assign if_b.in         = if_a.in;
  assign if_b.in_valid   = if_a.in_valid;
  assign if_b.pat_load   = if_a.pat_load;
  assign if_b.pat_in     = if_a.pat_in;
  assign if_b.overlap_en = if_a.overlap_en;
  assign if_b.count_clr  = if_a.count_clr;

  moore_seq_detector_p #(.PAT_W(PAT_W), .CNT_W(8), .RST_PAT(4'b1011)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  moore_seq_detector_p #(.PAT_W(PAT_W), .CNT_W(2), .RST_PAT(4'b1011)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the accepted bit stream since the last restart; the state is
  // the longest suffix of it that is a prefix of the pattern.
  bit         mq[$];
  logic [3:0] mpat;
  int         mst, mcnt_a, mcnt_b;

  function automatic int best();
    bit ok;
    for (int j = PAT_W; j >= 1; j--) begin
      if (j <= mq.size()) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++)
          if (mq[mq.size() - j + i] != mpat[PAT_W-1-i]) ok = 1'b0;
        if (ok) return j;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    mpat = 4'b1011; mq.delete(); mst = 0; mcnt_a = 0; mcnt_b = 0;
  endtask

  task automatic model_step(input logic b, v, ld, input logic [3:0] p, input logic ov, cl);
    bit hit;
    hit = 1'b0;
    if (ld) begin
      mpat = p; mq.delete(); mst = 0;
    end else if (v) begin
      if (mst == PAT_W && !ov) mq.delete();
      mq.push_back(b);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      mst = best();
      hit = (mst == PAT_W);
    end
    if (cl) begin
      mcnt_a = 0; mcnt_b = 0;
    end else if (hit) begin
      mcnt_a = (mcnt_a + 1 > 255) ? 255 : mcnt_a + 1;
      mcnt_b = (mcnt_b + 1 > 3)   ? 3   : mcnt_b + 1;
    end
  endtask

  task automatic cmp_model();
    chk("out_a", {31'd0, if_a.out}, {31'd0, mst == PAT_W});
    chk("cnt_a", {24'd0, if_a.match_count}, mcnt_a);
    chk("sat_a", {31'd0, if_a.count_sat}, {31'd0, mcnt_a == 255});
    chk("out_b", {31'd0, if_b.out}, {31'd0, mst == PAT_W});
    chk("cnt_b", {30'd0, if_b.match_count}, mcnt_b);
    chk("sat_b", {31'd0, if_b.count_sat}, {31'd0, mcnt_b == 3});
  endtask

  task automatic cyc(input logic b, v, ld, input logic [3:0] p, input logic ov, cl);
    if_a.in = b; if_a.in_valid = v; if_a.pat_load = ld;
    if_a.pat_in = p; if_a.overlap_en = ov; if_a.count_clr = cl;
    @(posedge clk);
    model_step(b, v, ld, p, ov, cl);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic b, v, ld; logic [3:0] p; logic ov, cl; logic eo; int ec;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic b, v, ld, input logic [3:0] p,
                     input logic ov, cl, eo, input int ec);
    vec_t t;
    t = '{b, v, ld, p, ov, cl, eo, ec};
    tbl.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0;
    if_a.in = 0; if_a.in_valid = 0; if_a.pat_load = 0;
    if_a.pat_in = 0; if_a.overlap_en = 1; if_a.count_clr = 0;
    model_reset();
    #3;
    cmp_model();
    @(negedge clk);
    rst_n = 1'b1;

    // overlap on, 1011 in stream 1011011
    add(1,1,0,0,1,0, 0,0); add(0,1,0,0,1,0, 0,0); add(1,1,0,0,1,0, 0,0);
    add(1,1,0,0,1,0, 1,1); add(0,1,0,0,1,0, 0,1); add(1,1,0,0,1,0, 0,1);
    add(1,1,0,0,1,0, 1,2);
    // reload 1011 + clear, same stream without overlap
    add(0,0,1,4'b1011,0,1, 0,0);
    add(1,1,0,0,0,0, 0,0); add(0,1,0,0,0,0, 0,0); add(1,1,0,0,0,0, 0,0);
    add(1,1,0,0,0,0, 1,1); add(0,1,0,0,0,0, 0,1); add(1,1,0,0,0,0, 0,1);
    add(1,1,0,0,0,0, 0,1);
    // 1111 with overlap: continuous detect
    add(0,0,1,4'b1111,1,1, 0,0);
    add(1,1,0,0,1,0, 0,0); add(1,1,0,0,1,0, 0,0); add(1,1,0,0,1,0, 0,0);
    add(1,1,0,0,1,0, 1,1); add(1,1,0,0,1,0, 1,2); add(1,1,0,0,1,0, 1,3);
    // load with a valid bit in the same cycle: bit is dropped; then fallback
    add(1,1,1,4'b1011,1,1, 0,0);
    add(1,1,0,0,1,0, 0,0); add(0,1,0,0,1,0, 0,0); add(1,1,0,0,1,0, 0,0);
    add(0,1,0,0,1,0, 0,0); add(1,1,0,0,1,0, 0,0); add(1,1,0,0,1,0, 1,1);

    foreach (tbl[i]) begin
      cyc(tbl[i].b, tbl[i].v, tbl[i].ld, tbl[i].p, tbl[i].ov, tbl[i].cl);
      chk("tbl_out", {31'd0, if_a.out}, {31'd0, tbl[i].eo});
      chk("tbl_cnt", {24'd0, if_a.match_count}, tbl[i].ec);
    end

    // invalid gap mid-pattern and while out is high
    cyc(0,0,1,4'b1011,1,1);
    cyc(1,1,0,0,1,0); cyc(0,1,0,0,1,0);
    for (int i = 0; i < 3; i++) cyc(i[0],0,0,0,1,0);
    cyc(1,1,0,0,1,0); cyc(1,1,0,0,1,0);
    chk("gap_det", {31'd0, if_a.out}, 1);
    cyc(0,0,0,0,1,0); cyc(1,0,0,0,1,0);
    chk("gap_hold_out", {31'd0, if_a.out}, 1);
    chk("gap_hold_cnt", {24'd0, if_a.match_count}, 1);

    // async reset mid-match
    cyc(1,1,0,0,1,0); cyc(0,1,0,0,1,0);
    #3 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_out", {31'd0, if_a.out}, 0);
    chk("rst_cnt", {24'd0, if_a.match_count}, 0);
    chk("rst_cnt_b", {30'd0, if_b.match_count}, 0);
    chk("rst_sat_b", {31'd0, if_b.count_sat}, 0);
    #4 rst_n = 1'b1;
    cyc(1,1,0,0,1,0); cyc(0,1,0,0,1,0); cyc(1,1,0,0,1,0); cyc(1,1,0,0,1,0);
    chk("post_rst_det", {31'd0, if_a.out}, 1);
    chk("post_rst_cnt", {24'd0, if_a.match_count}, 1);

    // saturation of the 2-bit counter, then clear racing a detect
    cyc(0,0,1,4'b1111,1,1);
    for (int i = 0; i < 8; i++) cyc(1,1,0,0,1,0);
    chk("sat_cnt_a", {24'd0, if_a.match_count}, 5);
    chk("sat_cnt_b", {30'd0, if_b.match_count}, 3);
    chk("sat_flag_b", {31'd0, if_b.count_sat}, 1);
    cyc(1,1,0,0,1,1);
    chk("clr_out", {31'd0, if_a.out}, 1);
    chk("clr_cnt_a", {24'd0, if_a.match_count}, 0);
    chk("clr_cnt_b", {30'd0, if_b.match_count}, 0);
    chk("clr_sat_b", {31'd0, if_b.count_sat}, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic b, v, ld, ov, cl;
      logic [3:0] p;
      b  = 1'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 39) == 0);
      p  = 4'($urandom);
      ov = ($urandom_range(0, 4) != 0);
      cl = ($urandom_range(0, 59) == 0);
      cyc(b, v, ld, p, ov, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
